alu_operand_stage: RTL and testbench

Parametrised operand-fetch pipeline stage between the register file read port and the ALU. It captures the register operands for one instruction and resolves read-after-write hazards by forwarding from up to `FWD_PORTS` later stages. It selects operand B as either a register or a sign/zero-extended immediate, and presents the operands to the ALU through a valid/ready handshake. A two-entry skid buffer keeps full throughput while remaining tolerant of ALU back-pressure.

---
 rtl/alu_operand_stage.sv | 177 +++++++++++++++++
 tb/tb_alu_operand_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// alu_operand_stage
//   Operand-fetch stage between the register file read port and the ALU.
//   Resolves read-after-write hazards by forwarding from FWD_PORTS later
//   stages (index 0 = youngest, highest priority), selects operand B as a
//   register or an extended immediate, and hands the operands to the ALU
//   through a two-entry (OUT + SKID) buffer.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
//   high. in_ready is registered (~SKID.valid) and has no path from out_ready.
//   While out_valid & ~out_ready the outputs stay frozen.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      upstream handshake
//   alu_in_sel               0: B = rs register, 1: B = extended immediate
//   imm_sext                 1: sign-extend offset, 0: zero-extend
//   rd_addr, rs_addr         source register addresses for A and B
//   rd_q, rs_q               register file read data
//   offset                   raw immediate
//   fwd_en/fwd_addr/fwd_data packed forwarding sources
//   out_valid / out_ready    ALU handshake
//   alu_a, alu_b, alu_imm    registered operands
//   fwd_hit                  bit0: A forwarded, bit1: B register path forwarded
module alu_operand_stage #(
    parameter int DWIDTH    = 16,
    parameter int AWIDTH    = 3,
    parameter int IMM_WIDTH = 8,
    parameter int FWD_PORTS = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           alu_in_sel,
    input  logic                           imm_sext,
    input  logic [AWIDTH-1:0]              rd_addr,
    input  logic [AWIDTH-1:0]              rs_addr,
    input  logic [DWIDTH-1:0]              rd_q,
    input  logic [DWIDTH-1:0]              rs_q,
    input  logic [IMM_WIDTH-1:0]           offset,
    input  logic [FWD_PORTS-1:0]           fwd_en,
    input  logic [FWD_PORTS*AWIDTH-1:0]    fwd_addr,
    input  logic [FWD_PORTS*DWIDTH-1:0]    fwd_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DWIDTH-1:0]              alu_a,
    output logic [DWIDTH-1:0]              alu_b,
    output logic [DWIDTH-1:0]              alu_imm,
    output logic [1:0]                     fwd_hit
);

    // State is exactly the pair (OUT.valid, SKID.valid); 2'b01 is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL1 = 2'b10,
        FULL2 = 2'b11
    } state_t;

    logic              out_valid_q, skid_valid_q;
    logic [DWIDTH-1:0] out_a_q, out_b_q, out_imm_q;
    logic [1:0]        out_hit_q;
    logic [DWIDTH-1:0] skid_a_q, skid_b_q, skid_imm_q;
    logic [1:0]        skid_hit_q;
    state_t            state;

    // Entry built from the current inputs (used only on accepting edges).
    logic [DWIDTH-1:0] in_a_d, in_b_d, in_imm_d;
    logic [1:0]        in_hit_d;

    logic [DWIDTH-1:0] a_res, rs_res, ext;
    logic              a_hit, rs_hit;
    logic              accept, drain;

    assign state = state_t'({out_valid_q, skid_valid_q});

    // Lowest-indexed matching source wins: iterate from the oldest so the
    // youngest match overwrites last.
    always_comb begin
        a_res  = rd_q;
        a_hit  = 1'b0;
        rs_res = rs_q;
        rs_hit = 1'b0;
        for (int i = FWD_PORTS - 1; i >= 0; i--) begin
            if (fwd_en[i] && (fwd_addr[i*AWIDTH +: AWIDTH] == rd_addr)) begin
                a_res = fwd_data[i*DWIDTH +: DWIDTH];
                a_hit = 1'b1;
            end
            if (fwd_en[i] && (fwd_addr[i*AWIDTH +: AWIDTH] == rs_addr)) begin
                rs_res = fwd_data[i*DWIDTH +: DWIDTH];
                rs_hit = 1'b1;
            end
        end
    end

    generate
        if (IMM_WIDTH < DWIDTH) begin : g_ext
            assign ext = {{(DWIDTH-IMM_WIDTH){imm_sext & offset[IMM_WIDTH-1]}}, offset};
        end else begin : g_noext
            assign ext = offset;
        end
    endgenerate

    assign in_a_d   = a_res;
    assign in_b_d   = alu_in_sel ? ext : rs_res;
    assign in_imm_d = ext;
    // The rs hit only matters when B actually came from the register path.
    assign in_hit_d = {rs_hit & ~alu_in_sel, a_hit};

    // Held low during reset so nothing is accepted while the buffer clears.
    assign in_ready = ~skid_valid_q & ~rst;
    assign accept   = in_valid & in_ready;
    assign drain    = out_valid_q & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_a_q      <= '0;
            out_b_q      <= '0;
            out_imm_q    <= '0;
            out_hit_q    <= '0;
            skid_a_q     <= '0;
            skid_b_q     <= '0;
            skid_imm_q   <= '0;
            skid_hit_q   <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        out_a_q     <= in_a_d;
                        out_b_q     <= in_b_d;
                        out_imm_q   <= in_imm_d;
                        out_hit_q   <= in_hit_d;
                        out_valid_q <= 1'b1;
                    end
                end
                FULL1: begin
                    if (accept && drain) begin
                        out_a_q   <= in_a_d;
                        out_b_q   <= in_b_d;
                        out_imm_q <= in_imm_d;
                        out_hit_q <= in_hit_d;
                    end else if (accept) begin
                        skid_a_q     <= in_a_d;
                        skid_b_q     <= in_b_d;
                        skid_imm_q   <= in_imm_d;
                        skid_hit_q   <= in_hit_d;
                        skid_valid_q <= 1'b1;
                    end else if (drain) begin
                        out_valid_q <= 1'b0;
                    end
                end
                FULL2: begin
                    // in_ready is low here, so only a drain can happen.
                    if (drain) begin
                        out_a_q      <= skid_a_q;
                        out_b_q      <= skid_b_q;
                        out_imm_q    <= skid_imm_q;
                        out_hit_q    <= skid_hit_q;
                        skid_valid_q <= 1'b0;
                    end
                end
                default: begin
                    out_valid_q  <= 1'b0;
                    skid_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign alu_a     = out_a_q;
    assign alu_b     = out_b_q;
    assign alu_imm   = out_imm_q;
    assign fwd_hit   = out_hit_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;
    localparam int W = 50;  // {a, b, imm, fwd_hit}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        alu_in_sel = 1'b0;
    logic        imm_sext = 1'b0;
    logic [2:0]  rd_addr = '0, rs_addr = '0;
    logic [15:0] rd_q = '0, rs_q = '0;
    logic [7:0]  offset = '0;
    logic [1:0]  fwd_en = '0;
    logic [5:0]  fwd_addr = '0;
    logic [31:0] fwd_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] alu_a, alu_b, alu_imm;
    logic [1:0]  fwd_hit;

    alu_operand_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_in_sel(alu_in_sel), .imm_sext(imm_sext),
        .rd_addr(rd_addr), .rs_addr(rs_addr),
        .rd_q(rd_q), .rs_q(rs_q), .offset(offset),
        .fwd_en(fwd_en), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_imm(alu_imm), .fwd_hit(fwd_hit)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int pass_cnt  = 0;
    int total_cnt = 0;
    int xfer_cnt  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: explicit priority chain for two sources.
    function automatic logic [W-1:0] model();
        logic [15:0] a, rsv, ext, b;
        logic        ha, hr;
        ext = imm_sext ? {{8{offset[7]}}, offset} : {8'h00, offset};
        if (fwd_en[0] && fwd_addr[2:0] == rd_addr)      begin a = fwd_data[15:0];  ha = 1'b1; end
        else if (fwd_en[1] && fwd_addr[5:3] == rd_addr) begin a = fwd_data[31:16]; ha = 1'b1; end
        else                                            begin a = rd_q;            ha = 1'b0; end
        if (fwd_en[0] && fwd_addr[2:0] == rs_addr)      begin rsv = fwd_data[15:0];  hr = 1'b1; end
        else if (fwd_en[1] && fwd_addr[5:3] == rs_addr) begin rsv = fwd_data[31:16]; hr = 1'b1; end
        else                                            begin rsv = rs_q;            hr = 1'b0; end
        b = alu_in_sel ? ext : rsv;
        return {a, b, ext, (hr && !alu_in_sel), ha};
    endfunction

    // Inputs change only at posedge+1, so the negedge sees what the next
    // edge will act on.
    logic         stalled = 1'b0;
    logic [W-1:0] held;
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", {alu_a, alu_b, alu_imm, fwd_hit}, held);
            end
            if (out_valid && out_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) check("unexpected_output", 1, 0);
                else check("sb_data", {alu_a, alu_b, alu_imm, fwd_hit}, exp_q.pop_front());
            end
            stalled = out_valid && !out_ready;
            held    = {alu_a, alu_b, alu_imm, fwd_hit};
            if (in_valid && in_ready) exp_q.push_back(model());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [15:0] a, input logic [15:0] b, input logic sel,
                             input logic sx, input logic [7:0] off);
        rd_q = a; rs_q = b; alu_in_sel = sel; imm_sext = sx; offset = off;
    endtask

    task automatic drain_all();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && (exp_q.size() != 0 || out_valid); i++) step();
        check("drain_empty", exp_q.size(), 0);
    endtask

    int low_cnt;
    int x0;

    // ---------------- directed sequence ----------------
    initial begin
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_outputs", {alu_a, alu_b, alu_imm, fwd_hit}, 0);
        step(); step();
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // Mid-stream reset
        out_ready = 1'b0;
        set_instr(16'h7777, 16'h8888, 1'b0, 1'b0, 8'h12);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_outputs", {alu_a, alu_b, alu_imm, fwd_hit}, 0);
        step();
        rst = 1'b0;
        #1;

        // Basic path
        out_ready = 1'b1;
        set_instr(16'h1234, 16'hABCD, 1'b0, 1'b0, 8'h00);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("basic_valid", out_valid, 1);
        check("basic_a", alu_a, 16'h1234);
        check("basic_b", alu_b, 16'hABCD);
        step();

        // Immediate extension; rs matches source 0 but B is the immediate
        rd_addr = 3'd1; rs_addr = 3'd5;
        fwd_en = 2'b01; fwd_addr = {3'd0, 3'd5}; fwd_data = {16'h0, 16'h5555};
        set_instr(16'h0101, 16'h0202, 1'b1, 1'b1, 8'h80);
        in_valid = 1'b1;
        step();
        check("sext_b", alu_b, 16'hFF80);
        check("sext_imm", alu_imm, 16'hFF80);
        check("sext_hit", fwd_hit, 2'b00);
        imm_sext = 1'b0;
        step();
        in_valid = 1'b0;
        check("zext_b", alu_b, 16'h0080);
        check("zext_imm", alu_imm, 16'h0080);
        check("zext_hit", fwd_hit, 2'b00);
        step();

        // Forwarding priority
        rd_addr = 3'd3; rs_addr = 3'd0;
        fwd_en = 2'b11; fwd_addr = {3'd3, 3'd3}; fwd_data = {16'h2222, 16'h1111};
        set_instr(16'h3333, 16'h4444, 1'b0, 1'b0, 8'h00);
        in_valid = 1'b1;
        step();
        check("fwd_pri_a", alu_a, 16'h1111);
        check("fwd_pri_hit", fwd_hit, 2'b01);
        fwd_en = 2'b10;
        step();
        in_valid = 1'b0;
        check("fwd_src1_a", alu_a, 16'h2222);
        rs_addr = 3'd3; alu_in_sel = 1'b0; fwd_en = 2'b01;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("fwd_b_path", {alu_b, fwd_hit}, {16'h1111, 2'b11});
        step();
        fwd_en = 2'b00; rd_addr = 3'd0; rs_addr = 3'd0;

        // Back-pressure
        set_instr(16'h0001, 16'h0000, 1'b0, 1'b0, 8'h00);
        in_valid = 1'b1;
        step();                               // 1 in OUT
        out_ready = 1'b0;
        rd_q = 16'h0002;
        step();                               // 2 into SKID
        check("bp_in_ready_low", in_ready, 0);
        check("bp_hold1", alu_a, 16'h0001);
        rd_q = 16'h0003;
        step();
        check("bp_hold2", alu_a, 16'h0001);
        step();
        check("bp_hold3", alu_a, 16'h0001);
        out_ready = 1'b1;
        step();                               // 1 leaves, 2 moves to OUT
        check("bp_skid_move", alu_a, 16'h0002);
        check("bp_in_ready_back", in_ready, 1);
        step();                               // 3 accepted, 2 leaves
        rd_q = 16'h0004;
        check("bp_third", alu_a, 16'h0003);
        step();
        in_valid = 1'b0;
        check("bp_fourth", alu_a, 16'h0004);
        drain_all();

        // Full throughput
        low_cnt = 0;
        x0 = xfer_cnt;
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rd_q = 16'($urandom_range(0, 65535));
            rs_q = 16'($urandom_range(0, 65535));
            offset = 8'($urandom_range(0, 255));
            if (!in_ready) low_cnt++;
            step();
        end
        in_valid = 1'b0;
        step();
        check("tp_transfers", xfer_cnt - x0, 16);
        check("tp_in_ready_low", low_cnt, 0);
        drain_all();

        // Reset in FULL2
        out_ready = 1'b0;
        in_valid = 1'b1;
        rd_q = 16'hDEAD;
        step();
        rd_q = 16'hBEEF;
        step();
        in_valid = 1'b0;
        check("full2_valid", out_valid, 1);
        check("full2_in_ready", in_ready, 0);
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("full2_rst_valid", out_valid, 0);
        check("full2_rst_a", alu_a, 0);
        step();
        rst = 1'b0;
        #1;
        out_ready = 1'b1;
        set_instr(16'h5A5A, 16'hA5A5, 1'b0, 1'b0, 8'h00);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("fresh_after_rst", {alu_a, alu_b}, {16'h5A5A, 16'hA5A5});
        step();
        check("fresh_single", out_valid, 0);

        // Random traffic with random back-pressure and forwarding
        for (int i = 0; i < 40; i++) begin
            in_valid   = 1'($urandom_range(0, 1));
            out_ready  = 1'($urandom_range(0, 1));
            alu_in_sel = 1'($urandom_range(0, 1));
            imm_sext   = 1'($urandom_range(0, 1));
            rd_addr    = 3'($urandom_range(0, 7));
            rs_addr    = 3'($urandom_range(0, 7));
            rd_q       = 16'($urandom_range(0, 65535));
            rs_q       = 16'($urandom_range(0, 65535));
            offset     = 8'($urandom_range(0, 255));
            fwd_en     = 2'($urandom_range(0, 3));
            fwd_addr   = 6'($urandom_range(0, 63));
            fwd_data   = {16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535))};
            step();
        end
        drain_all();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
